// File: rtl/ctrl_pipeline_pkg.sv
// Shared definitions for the control pipeline: opcodes, ALUOp and forwarding
// encodings, and the per-stage control records carried down the pipe.
package ctrl_pipeline_pkg;

  localparam int CP_REG_AW  = 5;
  localparam int CP_ALUOP_W = 2;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [CP_ALUOP_W-1:0] ALU_ADD    = 2'b00;
  localparam logic [CP_ALUOP_W-1:0] ALU_BRANCH = 2'b01;
  localparam logic [CP_ALUOP_W-1:0] ALU_RTYPE  = 2'b10;
  localparam logic [CP_ALUOP_W-1:0] ALU_ITYPE  = 2'b11;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  memto_reg;
    logic                  is_branch;
    logic                  alu_src;
    logic [CP_ALUOP_W-1:0] alu_op;
    logic [CP_REG_AW-1:0]  rs1;
    logic [CP_REG_AW-1:0]  rs2;
    logic [CP_REG_AW-1:0]  rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 memto_reg;
    logic [CP_REG_AW-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                 reg_write;
    logic                 memto_reg;
    logic [CP_REG_AW-1:0] rd;
  } wb_ctrl_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard_fwd.sv
// Combinational load-use detection and ALU operand forwarding selects.
module hazard_fwd_unit
  import ctrl_pipeline_pkg::*;
#(
  parameter int REG_AW = CP_REG_AW
) (
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] ex_rs1_i,
  input  logic [REG_AW-1:0] ex_rs2_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic              load_use_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  // The younger producer (MEM) wins over WB; x0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_select(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == src)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    load_use_o = id_valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
                 ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    fwd_a_o    = fwd_select(ex_rs1_i);
    fwd_b_o    = fwd_select(ex_rs2_i);
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries decoded control from ID through the EX, MEM and WB pipeline registers,
// with load-use stalling, branch flushing and forwarding selects.
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
#(
  parameter int REG_AW  = CP_REG_AW,
  parameter int ALUOP_W = CP_ALUOP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [6:0]         id_opcode,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_memto_reg,
  input  logic               id_is_branch,
  input  logic               id_alu_src,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               ex_zero,
  output logic               stall,
  output logic               flush_if_id,
  output logic               pc_src,
  output logic               illegal_op,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               mem_mem_read,
  output logic               mem_mem_write,
  output logic               wb_reg_write,
  output logic               wb_memto_reg,
  output logic [REG_AW-1:0]  wb_rd
);

  ex_ctrl_t  ex_q,  ex_d;
  mem_ctrl_t mem_q, mem_d;
  wb_ctrl_t  wb_q,  wb_d;
  logic      init_q;

  logic       load_use;
  logic       branch_taken;
  logic       opcode_legal;
  logic       capture;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  hazard_fwd_unit #(
    .REG_AW(REG_AW)
  ) u_hazard_fwd (
    .id_valid_i      (id_valid),
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .ex_mem_read_i   (ex_q.mem_read),
    .ex_rd_i         (ex_q.rd),
    .ex_rs1_i        (ex_q.rs1),
    .ex_rs2_i        (ex_q.rs2),
    .mem_reg_write_i (mem_q.reg_write),
    .mem_rd_i        (mem_q.rd),
    .wb_reg_write_i  (wb_q.reg_write),
    .wb_rd_i         (wb_q.rd),
    .load_use_o      (load_use),
    .fwd_a_o         (fwd_a_raw),
    .fwd_b_o         (fwd_b_raw)
  );

  // A taken branch outranks both the load-use stall and the illegal-opcode pulse,
  // since the ID instruction is being squashed anyway.
  always_comb begin
    branch_taken = ex_q.is_branch && ex_zero;
    opcode_legal = is_legal_op(id_opcode);
    pc_src       = branch_taken && !rst;
    flush_if_id  = pc_src;
    stall        = load_use && !branch_taken && !rst;
    illegal_op   = id_valid && !opcode_legal && !branch_taken && !load_use &&
                   !rst && !init_q;
    fwd_a        = rst ? '0 : fwd_a_raw;
    fwd_b        = rst ? '0 : fwd_b_raw;
    capture      = id_valid && opcode_legal && !load_use && !branch_taken;
  end

  // NOTE: every field gets a default before the conditional fill, so no latch
  // is inferred and a bubble is simply the all-zero record.
  always_comb begin
    ex_d = '0;
    if (capture) begin
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.mem_write = id_mem_write;
      ex_d.memto_reg = id_memto_reg && id_reg_write;
      ex_d.is_branch = id_is_branch;
      ex_d.alu_src   = id_alu_src;
      ex_d.alu_op    = id_alu_op;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
    end

    mem_d.reg_write = ex_q.reg_write;
    mem_d.mem_read  = ex_q.mem_read;
    mem_d.mem_write = ex_q.mem_write;
    mem_d.memto_reg = ex_q.memto_reg;
    mem_d.rd        = ex_q.rd;

    wb_d.reg_write  = mem_q.reg_write;
    wb_d.memto_reg  = mem_q.memto_reg;
    wb_d.rd         = mem_q.rd;
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous stage's value from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      init_q <= 1'b1;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      init_q <= 1'b0;
    end
  end

  always_comb begin
    ex_alu_op     = ex_q.alu_op;
    ex_alu_src    = ex_q.alu_src;
    mem_mem_read  = mem_q.mem_read;
    mem_mem_write = mem_q.mem_write;
    wb_reg_write  = wb_q.reg_write;
    wb_memto_reg  = wb_q.memto_reg;
    wb_rd         = wb_q.rd;
  end

endmodule
